// File: rtl/dmem_stall_ctrl_if.sv
// ============================================================================
// Module      : dmem_stall_ctrl_if
// Description : Request/response bundle between the memory stage and the
//               stalling data-memory block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_stall_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

`default_nettype wire

// File: rtl/dmem_stall_ctrl.sv
// ============================================================================
// Module      : dmem_stall_ctrl
// Description : Word-organised data memory with fixed access latency, byte/
//               halfword/word lanes, error flagging and a pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_stall_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dmem_stall_ctrl_if.slave   bus
);
    localparam int             c_idx_w  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]     c_lat_m1 = 4'(LATENCY - 1);
    localparam logic [ADDR_W-3:0] c_depth = (ADDR_W-2)'(DEPTH_WORDS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_stall_ctrl: LATENCY must lie in 1..15");
    end
    if (DATA_W != 32) begin : g_bad_width
        $error("dmem_stall_ctrl: lane logic supports DATA_W = 32 only");
    end

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [c_idx_w-1:0] w_idx;
    logic               w_err;
    logic               w_resp;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            c_st_idle: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = c_lat_m1;
                    state_d  = (LATENCY == 1) ? c_st_resp : c_st_wait;
                end
            end
            c_st_wait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = c_st_resp;
                end
            end
            c_st_resp: state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_st_idle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign w_resp = (state_q == c_st_resp);
    assign w_idx  = addr_q[2 +: c_idx_w];
    assign w_err  = (size_q == 2'b11)
                  || (size_q == 2'b01 && addr_q[0])
                  || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
                  || (addr_q[ADDR_W-1:2] >= c_depth);

    // Narrow store data is replicated across the word so the byte enables alone pick the lane.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                w_be     = 4'b0001 << addr_q[1:0];
                w_wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be     = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata_q[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Stores commit on the edge leaving RESP; an async reset forces IDLE and drops them.
    always_ff @(posedge clk) begin
        if (w_resp && we_q && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    assign w_word = mem_q[w_idx];
    assign w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (addr_q[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        case (size_q)
            2'b00:   w_load = {{24{signed_q & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{signed_q & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    assign bus.req_ready = (state_q == c_st_idle);
    assign bus.rsp_valid = w_resp;
    assign bus.rsp_err   = w_resp && w_err;
    assign bus.rsp_rdata = (w_resp && !we_q && !w_err) ? w_load : '0;
    assign bus.stall     = ((state_q == c_st_idle) && bus.req_valid) || (state_q == c_st_wait);

endmodule

`default_nettype wire

// File: tb/tb_dmem_stall_ctrl.sv
// ============================================================================
// Module      : tb_dmem_stall_ctrl
// Description : Directed bench for dmem_stall_ctrl at LATENCY 2, 1 and 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_stall_ctrl;
    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        m_ready, m_rsp_valid, m_err, m_stall;
    logic [31:0] m_rdata;
    int          total;
    int          bad;
    logic [31:0] model [16];

    dmem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    dmem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if_b ();
    dmem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if_c ();

    dmem_stall_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(2))
        u_lat2 (.clk(clk), .rst_n(rst_n), .bus(if_a));
    dmem_stall_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(1))
        u_lat1 (.clk(clk), .rst_n(rst_n), .bus(if_b));
    dmem_stall_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(5))
        u_lat5 (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_a.req_valid = req_valid && (sel == 2'd0);
    assign if_b.req_valid = req_valid && (sel == 2'd1);
    assign if_c.req_valid = req_valid && (sel == 2'd2);
    assign if_a.req_we = req_we;       assign if_b.req_we = req_we;       assign if_c.req_we = req_we;
    assign if_a.req_size = req_size;   assign if_b.req_size = req_size;   assign if_c.req_size = req_size;
    assign if_a.req_signed = req_signed; assign if_b.req_signed = req_signed; assign if_c.req_signed = req_signed;
    assign if_a.req_addr = req_addr;   assign if_b.req_addr = req_addr;   assign if_c.req_addr = req_addr;
    assign if_a.req_wdata = req_wdata; assign if_b.req_wdata = req_wdata; assign if_c.req_wdata = req_wdata;

    assign m_ready     = (sel == 2'd0) ? if_a.req_ready : (sel == 2'd1) ? if_b.req_ready : if_c.req_ready;
    assign m_rsp_valid = (sel == 2'd0) ? if_a.rsp_valid : (sel == 2'd1) ? if_b.rsp_valid : if_c.rsp_valid;
    assign m_rdata     = (sel == 2'd0) ? if_a.rsp_rdata : (sel == 2'd1) ? if_b.rsp_rdata : if_c.rsp_rdata;
    assign m_err       = (sel == 2'd0) ? if_a.rsp_err   : (sel == 2'd1) ? if_b.rsp_err   : if_c.rsp_err;
    assign m_stall     = (sel == 2'd0) ? if_a.stall     : (sel == 2'd1) ? if_b.stall     : if_c.stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with handshake, stall and latency checks along the way.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                          output logic [31:0] rd, output logic er);
        int n;
        req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        #1;
        total++;
        if (m_ready !== 1'b1 || m_stall !== 1'b1) begin
            bad++;
            $display("FAIL accept_hs addr=%h ready=%b stall=%b required 1 1", a, m_ready, m_stall);
        end
        cyc();
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_size = ~sz;
        #1;
        n = 0;
        while (m_rsp_valid !== 1'b1 && n < 40) begin
            total++;
            if (m_stall !== 1'b1 || m_ready !== 1'b0) begin
                bad++;
                $display("FAIL wait_hs addr=%h stall=%b ready=%b required 1 0", a, m_stall, m_ready);
            end
            n++;
            cyc();
        end
        total++;
        if (n + 1 != exp_lat) begin
            bad++;
            $display("FAIL latency addr=%h got=%0d required=%0d", a, n + 1, exp_lat);
        end
        rd = m_rdata;
        er = m_err;
        total++;
        if (m_stall !== 1'b0 || m_ready !== 1'b0) begin
            bad++;
            $display("FAIL resp_hs addr=%h stall=%b ready=%b required 0 0", a, m_stall, m_ready);
        end
        cyc();
        total++;
        if (m_rsp_valid !== 1'b0 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_resp rsp_valid=%b ready=%b required 0 1", m_rsp_valid, m_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) cyc();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            total++;
            if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_rdata !== 32'h0 || m_err !== 1'b0 || m_stall !== 1'b0) begin
                bad++;
                $display("FAIL reset_state dut=%0d ready=%b valid=%b rdata=%h err=%b stall=%b required 1 0 0 0 0",
                         s, m_ready, m_rsp_valid, m_rdata, m_err, m_stall);
            end
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        sel = 2'd0;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, rd, er);
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            bad++; $display("FAIL store_word rdata=%h err=%b required 0 0", rd, er);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("FAIL load_word rdata=%h err=%b required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic        er;
        sel = 2'd0;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2, rd, er);
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AA, 2, rd, er);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'h1122AA44) begin bad++; $display("FAIL byte_store rdata=%h required 1122aa44", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb_signed rdata=%h required ffffffaa", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'h000000AA) begin bad++; $display("FAIL lb_unsigned rdata=%h required 000000aa", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'h00001122) begin bad++; $display("FAIL lh_signed_hi rdata=%h required 00001122", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'hFFFFAA44) begin bad++; $display("FAIL lh_signed_lo rdata=%h required ffffaa44", rd); end
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h9999BEEF, 2, rd, er);
        do_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'hBEEFAA44 || er !== 1'b0) begin
            bad++; $display("FAIL half_store rdata=%h err=%b required beefaa44 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        logic [31:0] e_addr [4];
        logic [1:0]  e_size [4];
        logic [31:0] e_word [4];
        logic [31:0] e_init [4];
        e_addr = '{32'h03, 32'h06, 32'h08, 32'h400};
        e_size = '{2'b01, 2'b10, 2'b11, 2'b10};
        e_word = '{32'h00, 32'h04, 32'h08, 32'h0C};
        e_init = '{32'hCAFEF00D, 32'h0BADF00D, 32'h01020304, 32'h5A5A5A5A};
        sel = 2'd0;
        for (int i = 0; i < 4; i++) do_req(1'b1, 2'b10, 1'b0, e_word[i], e_init[i], 2, rd, er);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, e_size[i], 1'b0, e_addr[i], 32'hFFFFFFFF, 2, rd, er);
            total++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                bad++; $display("FAIL err_store%0d err=%b rdata=%h required 1 0", i, er, rd);
            end
            do_req(1'b0, e_size[i], 1'b1, e_addr[i], 32'h0, 2, rd, er);
            total++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                bad++; $display("FAIL err_load%0d err=%b rdata=%h required 1 0", i, er, rd);
            end
            do_req(1'b0, 2'b10, 1'b0, e_word[i], 32'h0, 2, rd, er);
            total++;
            if (rd !== e_init[i] || er !== 1'b0) begin
                bad++; $display("FAIL err_unchanged%0d rdata=%h required %h", i, rd, e_init[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        logic [31:0] vals [3];
        vals = '{32'h11110001, 32'h22220002, 32'h33330003};
        sel = 2'd1;
        for (int i = 0; i < 3; i++) do_req(1'b1, 2'b10, 1'b0, 32'h30 + 32'(4*i), vals[i], 1, rd, er);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h30 + 32'(4*i);
            #1;
            total++;
            if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_idle%0d ready=%b valid=%b required 1 0", i, m_ready, m_rsp_valid);
            end
            cyc();
            total++;
            if (m_rsp_valid !== 1'b1 || m_ready !== 1'b0 || m_rdata !== vals[i] || m_err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_resp%0d valid=%b ready=%b rdata=%h err=%b required 1 0 %h 0",
                         i, m_rsp_valid, m_ready, m_rdata, m_err, vals[i]);
            end
            cyc();
        end
        req_valid = 1'b0;
        #1;
        total++;
        if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_end ready=%b valid=%b required 1 0", m_ready, m_rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        sel = 2'd0;
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 2, rd, er);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'h55;
        req_valid = 1'b1;
        #1;
        cyc();
        req_valid = 1'b0;
        #1;
        total++;
        if (m_stall !== 1'b1 || m_ready !== 1'b0) begin
            bad++; $display("FAIL mid_wait stall=%b ready=%b required 1 0", m_stall, m_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_rdata !== 32'h0 || m_err !== 1'b0 || m_stall !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset ready=%b valid=%b rdata=%h err=%b stall=%b required 1 0 0 0 0",
                     m_ready, m_rsp_valid, m_rdata, m_err, m_stall);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (m_rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_novalid%0d valid=%b required 0", i, m_rsp_valid); end
        end
        rst_n = 1'b1;
        cyc();
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, rd, er);
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            bad++; $display("FAIL mid_readback rdata=%h err=%b required 0 0", rd, er);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] rd, exp_rd, w, wd, a;
        logic        er, we, sgn;
        logic [1:0]  sz;
        logic [7:0]  b;
        logic [15:0] h;
        int          k, off;
        sel = 2'd2;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_req(1'b1, 2'b10, 1'b0, 32'h200 + 32'(4*i), model[i], 5, rd, er);
        end
        for (int t = 0; t < 24; t++) begin
            k   = $urandom_range(0, 15);
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'b00) ? $urandom_range(0, 3) : (sz == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            wd  = $urandom;
            a   = 32'h200 + 32'(4*k + off);
            w   = model[k];
            b   = 8'(w >> (8*off));
            h   = 16'(w >> (8*off));
            case (sz)
                2'b00:   exp_rd = sgn ? {{24{b[7]}}, b} : {24'h0, b};
                2'b01:   exp_rd = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                default: exp_rd = w;
            endcase
            if (we) exp_rd = 32'h0;
            do_req(we, sz, sgn, a, wd, 5, rd, er);
            total++;
            if (rd !== exp_rd || er !== 1'b0) begin
                bad++;
                $display("FAIL sweep%0d we=%b size=%0d addr=%h rdata=%h err=%b required %h 0",
                         t, we, sz, a, rd, er, exp_rd);
            end
            if (we) begin
                case (sz)
                    2'b00:   model[k][8*off +: 8]  = wd[7:0];
                    2'b01:   model[k][8*off +: 16] = wd[15:0];
                    default: model[k] = wd;
                endcase
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 2'd0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
